// File: rtl/bram_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bram_rr_arbiter_pkg
// Brief    : Shared FSM encodings, default widths and clog2 for the arbiter.
// Revision : 1.0
// ============================================================================
package bram_rr_arbiter_pkg;

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_ISSUE = 2'd1;
  localparam logic [1:0] c_ST_WAIT  = 2'd2;
  localparam logic [1:0] c_ST_RESP  = 2'd3;

  localparam int c_DEF_NUM_REQ     = 4;
  localparam int c_DEF_DATA_WIDTH  = 32;
  localparam int c_DEF_ADDR_WIDTH  = 32;
  localparam int c_DEF_WDOG_CYCLES = 15;

  // Never returns less than 1 so that derived index vectors stay legal.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bram_rr_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin picker: first set req bit at or above
//            pointer, wrapping modulo NUM_REQ.
// Revision : 1.0
// ============================================================================
module rr_pick
  import bram_rr_arbiter_pkg::*;
#(
  parameter int NUM_REQ = c_DEF_NUM_REQ,
  parameter int PTR_W   = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   pointer,
  output logic               valid,
  output logic [PTR_W-1:0]   index
);

  int w_j;

  // Scan from the farthest offset down so the nearest set bit is written last.
  always_comb begin
    valid = 1'b0;
    index = '0;
    w_j   = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_j = (int'(pointer) + k) % NUM_REQ;
      if (req[w_j]) begin
        valid = 1'b1;
        index = PTR_W'(w_j);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bram_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bram_rr_arbiter
// Brief    : Round-robin sequencer sharing one single-port BRAM controller
//            among NUM_REQ requesters. Optional watchdog: BRAM_RR_ARBITER_WDOG_EN.
// Revision : 1.0
// ============================================================================
module bram_rr_arbiter
  import bram_rr_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = c_DEF_NUM_REQ,
  parameter int DATA_WIDTH  = c_DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH  = c_DEF_ADDR_WIDTH,
  parameter int WDOG_CYCLES = c_DEF_WDOG_CYCLES
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            ack,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic                          err,
  output logic                          mem_req,
  output logic                          mem_access,
  output logic [ADDR_WIDTH-1:0]         mem_addr_in,
  output logic [DATA_WIDTH-1:0]         mem_data_in,
  input  logic [DATA_WIDTH-1:0]         mem_data_out,
  input  logic                          mem_done
);

  localparam int c_PTR_W = clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("bram_rr_arbiter: NUM_REQ must be in 2..8");
  end
  if (WDOG_CYCLES < 1) begin : g_bad_wdog
    $error("bram_rr_arbiter: WDOG_CYCLES must be at least 1");
  end

  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;
  logic [c_PTR_W-1:0]    r_ptr;
  logic [c_PTR_W-1:0]    r_grant;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  w_pick_valid;
  logic [c_PTR_W-1:0]    w_pick_idx;
  logic                  w_wdog_hit;
  logic                  w_timeout;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (c_PTR_W)
  ) u_rr_pick (
    .req     (req),
    .pointer (r_ptr),
    .valid   (w_pick_valid),
    .index   (w_pick_idx)
  );

`ifdef BRAM_RR_ARBITER_WDOG_EN
  localparam int c_WDOG_W = clog2(WDOG_CYCLES + 1);

  logic [c_WDOG_W-1:0] r_wdog;
  logic                r_timeout;

  // r_wdog counts completed WAIT cycles; the hit fires on the last allowed one.
  assign w_wdog_hit = (r_wdog == c_WDOG_W'(WDOG_CYCLES - 1));
  assign w_timeout  = r_timeout;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wdog    <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (r_state == c_ST_WAIT && !mem_done) r_wdog <= r_wdog + 1'b1;
      else                                   r_wdog <= '0;
      r_timeout <= (r_state == c_ST_WAIT) && !mem_done && w_wdog_hit;
    end
  end
`else
  assign w_wdog_hit = 1'b0;
  assign w_timeout  = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= c_ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE:  if (w_pick_valid) w_state_nxt = c_ST_ISSUE;
      c_ST_ISSUE: w_state_nxt = c_ST_WAIT;
      c_ST_WAIT:  if (mem_done || w_wdog_hit) w_state_nxt = c_ST_RESP;
      c_ST_RESP:  w_state_nxt = c_ST_IDLE;
      default:    w_state_nxt = c_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr   <= '0;
      r_grant <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      if (r_state == c_ST_IDLE && w_pick_valid) begin
        r_grant <= w_pick_idx;
        r_we    <= req_we[w_pick_idx];
        r_addr  <= req_addr[w_pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
        r_wdata <= req_wdata[w_pick_idx*DATA_WIDTH +: DATA_WIDTH];
      end
      if (r_state == c_ST_WAIT) begin
        if (mem_done)        r_rdata <= mem_data_out;
        else if (w_wdog_hit) r_rdata <= '0;
      end
      if (r_state == c_ST_RESP) begin
        r_ptr <= (r_grant == c_PTR_W'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;
      end
    end
  end

  always_comb begin
    mem_req     = (r_state == c_ST_ISSUE);
    mem_access  = r_we;
    mem_addr_in = r_addr;
    mem_data_in = r_wdata;
    rdata       = r_rdata;
    ack         = '0;
    err         = 1'b0;
    if (r_state == c_ST_RESP) begin
      ack = NUM_REQ'(1) << r_grant;
      err = w_timeout;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bram_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bram_rr_arbiter
// Brief    : Directed self-checking bench with a registered BRAM controller model.
// Revision : 1.0
// ============================================================================
module tb_bram_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 32;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N-1:0]    req, req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    ack;
  logic [DW-1:0]   rdata;
  logic            err;
  logic            mem_req, mem_access, mem_done;
  logic [AW-1:0]   mem_addr_in;
  logic [DW-1:0]   mem_data_in, mem_data_out;
  logic            done_en;
  logic [31:0]     mem [16];

  int total;
  int bad;

  always #5 clk = ~clk;

  bram_rr_arbiter #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WDOG_CYCLES(15)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .ack(ack), .rdata(rdata),
    .err(err), .mem_req(mem_req), .mem_access(mem_access),
    .mem_addr_in(mem_addr_in), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .mem_done(mem_done)
  );

  // Controller model: registered done echo and registered data, 16 words.
  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h100 + i;
      mem_done     <= 1'b0;
      mem_data_out <= '0;
    end else begin
      mem_done <= mem_req & done_en;
      if (mem_req) begin
        if (mem_access) begin
          mem[mem_addr_in[3:0]] <= mem_data_in;
          mem_data_out          <= mem_data_in;
        end else begin
          mem_data_out <= mem[mem_addr_in[3:0]];
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL time_limit: observed=running expected=finished");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int idx, input logic we, input logic [31:0] addr,
                         input logic [31:0] wd);
    req[idx]              = 1'b1;
    req_we[idx]           = we;
    req_addr[idx*AW +: AW]  = addr;
    req_wdata[idx*DW +: DW] = wd;
  endtask

  // Called in the IDLE cycle where the request is first visible (cycle 0).
  task automatic txn(input string tag, input int idx, input logic we,
                     input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd);
    tick();
    check({tag, ".c1_mem_req"}, 32'(mem_req), 32'd1);
    check({tag, ".c1_access"}, 32'(mem_access), 32'(we));
    check({tag, ".c1_addr"}, mem_addr_in, addr);
    check({tag, ".c1_wdata"}, mem_data_in, wd);
    tick();
    check({tag, ".c2_mem_req"}, 32'(mem_req), 32'd0);
    check({tag, ".c2_addr"}, mem_addr_in, addr);
    check({tag, ".c2_ack"}, 32'(ack), 32'd0);
    tick();
    check({tag, ".c3_ack"}, 32'(ack), 32'd1 << idx);
    check({tag, ".c3_rdata"}, rdata, rd);
    check({tag, ".c3_err"}, 32'(err), 32'd0);
    req[idx] = 1'b0;
    tick();
    check({tag, ".c4_ack"}, 32'(ack), 32'd0);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    reset_n   = 1'b0;
    req       = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    done_en   = 1'b1;
    repeat (3) tick();

    check("rst.ack", 32'(ack), 32'd0);
    check("rst.err", 32'(err), 32'd0);
    check("rst.mem_req", 32'(mem_req), 32'd0);
    check("rst.rdata", rdata, 32'd0);
    check("rst.addr", mem_addr_in, 32'd0);
    reset_n = 1'b1;
    tick();

    // Write then read back through requester 1.
    set_req(1, 1'b1, 32'd5, 32'hA5);
    txn("wr1", 1, 1'b1, 32'd5, 32'hA5, 32'hA5);
    set_req(1, 1'b0, 32'd5, 32'd0);
    txn("rd1", 1, 1'b0, 32'd5, 32'd0, 32'hA5);

    // From reset, all four requesters at once: served 0,1,2,3.
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) set_req(k, 1'b0, 32'(8 + k), 32'd0);
    for (int k = 0; k < 4; k++)
      txn($sformatf("all%0d", k), k, 1'b0, 32'(8 + k), 32'd0, 32'h108 + 32'(k));

    // Grant 2 leaves the pointer at 3, so 3 beats 0.
    set_req(2, 1'b0, 32'd2, 32'd0);
    txn("p2", 2, 1'b0, 32'd2, 32'd0, 32'h102);
    set_req(0, 1'b0, 32'd0, 32'd0);
    set_req(3, 1'b0, 32'd3, 32'd0);
    txn("wrap3", 3, 1'b0, 32'd3, 32'd0, 32'h103);
    txn("wrap0", 0, 1'b0, 32'd0, 32'd0, 32'h100);

    // Requester 2 pulses only during requester 0's WAIT.
    set_req(0, 1'b0, 32'd4, 32'd0);
    tick();
    check("wd.c1_addr", mem_addr_in, 32'd4);
    tick();
    set_req(2, 1'b0, 32'd9, 32'd0);
    tick();
    check("wd.c3_ack", 32'(ack), 32'd1);
    req = '0;
    for (int c = 0; c < 6; c++) begin
      tick();
      check($sformatf("wd.idle%0d", c), {30'd0, mem_req, ack[2]}, 32'd0);
    end

    // Reset in the middle of a write's WAIT cycle.
    set_req(1, 1'b1, 32'd7, 32'h77);
    tick();
    tick();
    check("mr.c2_access", 32'(mem_access), 32'd1);
    reset_n = 1'b0;
    #1;
    check("mr.mem_req", 32'(mem_req), 32'd0);
    check("mr.access", 32'(mem_access), 32'd0);
    check("mr.addr", mem_addr_in, 32'd0);
    check("mr.wdata", mem_data_in, 32'd0);
    check("mr.rdata", rdata, 32'd0);
    check("mr.ack", 32'(ack), 32'd0);
    req = '0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    set_req(2, 1'b0, 32'd5, 32'd0);
    txn("post", 2, 1'b0, 32'd5, 32'd0, 32'h105);

`ifdef BRAM_RR_ARBITER_WDOG_EN
    done_en = 1'b0;
    set_req(3, 1'b0, 32'd6, 32'd0);
    tick();
    check("wdog.c1_mem_req", 32'(mem_req), 32'd1);
    for (int c = 2; c <= 16; c++) begin
      tick();
      check($sformatf("wdog.wait%0d", c), {27'd0, err, ack}, 32'd0);
    end
    tick();
    check("wdog.err", 32'(err), 32'd1);
    check("wdog.ack", 32'(ack), 32'd8);
    check("wdog.rdata", rdata, 32'd0);
    req = '0;
    tick();
    check("wdog.idle", {26'd0, mem_req, err, ack}, 32'd0);
    done_en = 1'b1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bram_rr_arbiter.md
Name: bram_rr_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one single-port BRAM controller (the `bramctrlsimple`-style req/access/done port) among NUM_REQ requesters.
- Serialises requests and drives one memory transaction at a time: mem_req pulse, then wait for mem_done.
- Returns read data and a one-cycle ack to the granted requester.
- Sits between client engines (e.g. GA population readers/writers) and the memory controller.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_WIDTH, 32, memory word width
- ADDR_WIDTH, 32, memory address width
- WDOG_CYCLES, 15, watchdog limit in cycles (used only with the optional feature)

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- req  input  NUM_REQ  per-requester request, held until ack
- req_we  input  NUM_REQ  per-requester write enable (1 = write, 0 = read)
- req_addr  input  NUM_REQ*ADDR_WIDTH  flat address bus; slice i belongs to requester i
- req_wdata  input  NUM_REQ*DATA_WIDTH  flat write-data bus
- ack  output  NUM_REQ  one-hot, one-cycle completion pulse
- rdata  output  DATA_WIDTH  read data, valid while any ack bit is high
- err  output  1  watchdog error pulse (0 when the feature is off)
- mem_req  output  1  to controller mem_req
- mem_access  output  1  to controller mem_access (1 = write)
- mem_addr_in  output  ADDR_WIDTH  to controller
- mem_data_in  output  DATA_WIDTH  to controller
- mem_data_out  input  DATA_WIDTH  from controller, registered
- mem_done  input  1  from controller, registered echo of mem_req

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - All outputs are 0.
  - State is IDLE.
  - Round-robin pointer is 0.
  - Grant register is 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req bit is high, select the first set bit searching upward from the pointer, wrapping modulo NUM_REQ.
  - Latch grant index, req_we, req_addr slice and req_wdata slice into registers, then go to ISSUE.
  - No request means stay in IDLE.
- ISSUE:
  - mem_req = 1 for exactly one cycle.
  - mem_access, mem_addr_in and mem_data_in come from the latched registers.
  - Next state is WAIT.
- WAIT:
  - mem_req = 0; mem_addr_in and mem_data_in stay stable.
  - When mem_done = 1, capture mem_data_out into rdata (for writes too) and go to RESP.
- RESP:
  - ack[grant] = 1 for one cycle.
  - Pointer becomes (grant+1) mod NUM_REQ.
  - Next state is IDLE.
- Latency: req seen in cycle 0, mem_req in cycle 1, mem_done in cycle 2, ack in cycle 3. Back-to-back transactions run every 4 cycles.
- Requester rule: drop req on the edge after ack. The IDLE cycle after RESP therefore never sees a stale request.
- A req bit dropped before it is granted is ignored. Changes to req_addr/req_wdata after the grant have no effect.
- Simultaneous requests: only the pointer-ordered winner is served; the others wait. No requester waits more than NUM_REQ-1 transactions.
- mem_done in IDLE or ISSUE is ignored.
- Mid-transaction reset:
  - Everything returns to reset values immediately.
  - The in-flight memory write may still complete in the controller.
  - No ack is issued for it.
- Width rules: pointer and grant are clog2(NUM_REQ) bits. Slice i is [i*W +: W].

Optional Feature:
- Macro: BRAM_RR_ARBITER_WDOG_EN.
- Enabled:
  - A counter runs in WAIT.
  - If it reaches WDOG_CYCLES without mem_done, pulse err and ack[grant] for one cycle, with rdata = 0.
  - Advance the pointer and return to IDLE.
- Disabled:
  - No counter; WAIT waits indefinitely.
  - err is tied to 0.

Decomposition:
- Shared package/include:
  - FSM state encodings (2-bit: IDLE=0, ISSUE=1, WAIT=2, RESP=3)
  - clog2 function
  - Default widths
- One sub-module, rr_pick: combinational round-robin picker with inputs req and pointer, outputs valid and index.
- The FSM stays in bram_rr_arbiter.

Test Plan:
- Single write, then read: req[1]=1, we=1, addr=5, wdata=0xA5. Expect mem_req pulse at cycle 1 with access=1 and addr=5, ack=4'b0010 at cycle 3. A read of addr 5 returns rdata=0xA5 with ack.
- Simultaneous req=4'b1111 from reset: grants go 0,1,2,3 in order, acks at cycles 3,7,11,15.
- Fairness wrap: pointer=3 after a grant to 2, req=4'b1001: requester 3 is served first, then 0.
- Early withdraw: req[2] pulsed while requester 0 is in WAIT, dropped before IDLE. No mem_req is issued for requester 2 and ack[2] stays 0.
- Reset mid-WAIT: assert reset_n=0 in cycle 2. All outputs are 0 immediately. After release, the next request completes normally in 4 cycles.
- With BRAM_RR_ARBITER_WDOG_EN: mem_done held 0 gives err=1 and ack[grant]=1 after 15 WAIT cycles, then returns to IDLE.
